fwrisc_fetch_buf: RTL and testbench



---
 rtl/fwrisc_fetch_pkg.sv | 21 ++
 rtl/fwrisc_fetch_fifo.sv | 70 +++++++
 rtl/fwrisc_fetch_buf.sv | 108 ++++++++++
 tb/tb_fwrisc_fetch_buf.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_fetch_pkg.sv
// Shared types and address helpers for the fwrisc instruction prefetch buffer.
package fwrisc_fetch_pkg;

    localparam logic [31:0] FETCH_RESET_ADDR = 32'h0000_0000;

    // RUN: beats are pushed; DROP: the in-flight beat belongs to a stale stream
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Wraps 32'hFFFF_FFFC -> 32'h0000_0000
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return word_align(addr) + 32'd4;
    endfunction

endpackage

// File: rtl/fwrisc_fetch_fifo.sv
// Small word FIFO holding prefetched instructions; head is visible combinationally.
module fwrisc_fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push,
    input  logic [31:0]                    push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [31:0]                    head_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; count guards every read of it
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fwrisc_fetch_buf.sv
// Sequential instruction prefetch buffer between the fwrisc fetch port and memory.
module fwrisc_fetch_buf
    import fwrisc_fetch_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_ADDR = FETCH_RESET_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic        iready,
    output logic [31:0] idata,
    output logic [31:0] maddr,
    output logic        mvalid,
    input  logic        mready,
    input  logic [31:0] mdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  head_addr_q, head_addr_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  redir_pc_q, redir_pc_d;

    logic [CW-1:0] count;
    logic [31:0]   head_data;
    logic          fifo_push, fifo_pop, fifo_flush;
    logic          addr_match, hit, miss, beat;

    fwrisc_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (mdata),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_data (head_data),
        .count     (count)
    );

    assign addr_match = (iaddr[31:2] == head_addr_q[31:2]);
    assign hit        = ivalid && (count != '0) && addr_match;
    assign miss       = ivalid && !addr_match;

    // A pending drop keeps the request alive even when the FIFO is full
    assign mvalid = !reset && ((count < DEPTH_C) || (state_q == ST_DROP));
    assign beat   = mvalid && mready;
    assign maddr  = fetch_pc_q;
    assign iready = hit && !reset;
    assign idata  = head_data;

    always_comb begin
        state_d     = state_q;
        head_addr_d = head_addr_q;
        fetch_pc_d  = fetch_pc_q;
        redir_pc_d  = redir_pc_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;

        if (miss) begin
            fifo_flush  = 1'b1;
            head_addr_d = word_align(iaddr);
            // maddr must not move under a stalled request, so park the target
            if (!mvalid || beat) begin
                fetch_pc_d = word_align(iaddr);
                state_d    = ST_RUN;
            end else begin
                redir_pc_d = word_align(iaddr);
                state_d    = ST_DROP;
            end
        end else begin
            if (hit) begin
                fifo_pop    = 1'b1;
                head_addr_d = next_word_addr(head_addr_q);
            end
            if (beat) begin
                if (state_q == ST_DROP) begin
                    fetch_pc_d = redir_pc_q;
                    state_d    = ST_RUN;
                end else begin
                    fifo_push  = 1'b1;
                    fetch_pc_d = next_word_addr(fetch_pc_q);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            head_addr_q <= RESET_ADDR;
            fetch_pc_q  <= RESET_ADDR;
            redir_pc_q  <= RESET_ADDR;
        end else begin
            state_q     <= state_d;
            head_addr_q <= head_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

endmodule

// File: tb/tb_fwrisc_fetch_buf.sv
// Directed bench for fwrisc_fetch_buf with a queue-based reference model checked every cycle.
module tb_fwrisc_fetch_buf;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] MEM_BASE = 32'h1000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;
    logic [31:0] idata;
    logic [31:0] maddr;
    logic        mvalid;
    logic        mready;
    logic [31:0] mdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    fwrisc_fetch_buf #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .iaddr  (iaddr),
        .ivalid (ivalid),
        .iready (iready),
        .idata  (idata),
        .maddr  (maddr),
        .mvalid (mvalid),
        .mready (mready),
        .mdata  (mdata)
    );

    // Memory image: every word holds MEM_BASE plus its own address
    assign mdata = MEM_BASE + maddr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // Reference model: the FIFO as a queue of expected words plus the address trackers
    logic [31:0] m_q[$];
    logic [31:0] m_head, m_fetch, m_redir;
    bit          m_drop;
    bit          prev_pend;
    logic [31:0] prev_addr;

    always @(negedge clock) begin
        bit          e_mv, e_hit, e_miss, e_beat;
        logic [31:0] tgt;
        if (reset) begin
            check("rst_iready", {31'b0, iready}, 32'd0);
            check("rst_mvalid", {31'b0, mvalid}, 32'd0);
            m_q.delete();
            m_head    = 32'h0;
            m_fetch   = 32'h0;
            m_redir   = 32'h0;
            m_drop    = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                check("hold_mvalid", {31'b0, mvalid}, 32'd1);
                check("hold_maddr", maddr, prev_addr);
            end
            tgt    = {iaddr[31:2], 2'b00};
            e_mv   = (m_q.size() < DEPTH) || m_drop;
            e_hit  = ivalid && (m_q.size() != 0) && (iaddr[31:2] == m_head[31:2]);
            e_miss = ivalid && (iaddr[31:2] != m_head[31:2]);
            check("m_iready", {31'b0, iready}, {31'b0, e_hit});
            if (e_hit) begin
                check("m_idata", idata, m_q[0]);
                check("m_idata_mem", idata, MEM_BASE + tgt);
            end
            check("m_mvalid", {31'b0, mvalid}, {31'b0, e_mv});
            if (e_mv) check("m_maddr", maddr, m_fetch);
            e_beat = e_mv && mready;
            if (e_miss) begin
                m_q.delete();
                m_head = tgt;
                if (!e_mv || e_beat) begin
                    m_fetch = tgt;
                    m_drop  = 1'b0;
                end else begin
                    m_redir = tgt;
                    m_drop  = 1'b1;
                end
            end else begin
                if (e_hit) begin
                    void'(m_q.pop_front());
                    m_head = m_head + 32'd4;
                end
                if (e_beat) begin
                    if (m_drop) begin
                        m_fetch = m_redir;
                        m_drop  = 1'b0;
                    end else begin
                        m_q.push_back(MEM_BASE + m_fetch);
                        m_fetch = m_fetch + 32'd4;
                    end
                end
            end
            prev_pend = mvalid && !mready;
            prev_addr = maddr;
        end
    end

    // One cycle: drive after the active edge, return at the sampling edge
    task automatic cyc(input logic r, input logic iv, input logic [31:0] ia, input logic mr);
        @(posedge clock);
        #1;
        reset  = r;
        ivalid = iv;
        iaddr  = ia;
        mready = mr;
        @(negedge clock);
        cyc_no++;
        $display("[TB] cyc %0d rst=%0b ivalid=%0b iaddr=%h iready=%0b idata=%h mvalid=%0b maddr=%h mready=%0b",
                 cyc_no, reset, ivalid, iaddr, iready, idata, mvalid, maddr, mready);
    endtask

    int beats;

    initial begin
        reset  = 1'b1;
        ivalid = 1'b0;
        iaddr  = 32'h0;
        mready = 1'b0;

        cyc(1, 0, 32'h0, 1);
        cyc(1, 0, 32'h0, 1);
        check("lit_rst_mvalid", {31'b0, mvalid}, 32'd0);

        // Cold start from the reset address
        cyc(0, 1, 32'h0, 1);
        check("lit_cold_iready", {31'b0, iready}, 32'd0);
        check("lit_cold_maddr", maddr, 32'h0);
        cyc(0, 1, 32'h0, 1);
        check("lit_first_iready", {31'b0, iready}, 32'd1);
        check("lit_first_idata", idata, 32'h1000_0000);
        cyc(0, 1, 32'h4, 1);
        check("lit_seq4", idata, 32'h1000_0004);
        cyc(0, 1, 32'h8, 1);
        check("lit_seq8", {31'b0, iready}, 32'd1);
        cyc(0, 1, 32'hC, 1);
        check("lit_seqC", idata, 32'h1000_000C);

        // Stall: FIFO already holds 0x10, so one more beat fills it
        beats = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 32'h0, 1);
            if (mvalid && mready) beats++;
        end
        check("lit_stall_beats", beats, DEPTH - 1);
        check("lit_full_mvalid", {31'b0, mvalid}, 32'd0);

        // Drain the full FIFO without memory help
        cyc(0, 1, 32'h10, 0);
        check("lit_drain10", idata, 32'h1000_0010);
        cyc(0, 1, 32'h14, 0);
        check("lit_drain14", {31'b0, iready}, 32'd1);
        check("lit_stall_maddr", maddr, 32'h18);

        // Redirect under a stalled request, then a second redirect during the drop
        cyc(0, 1, 32'h200, 0);
        check("lit_redir_iready", {31'b0, iready}, 32'd0);
        cyc(0, 1, 32'h200, 0);
        check("lit_drop_maddr", maddr, 32'h18);
        cyc(0, 1, 32'h300, 0);
        cyc(0, 1, 32'h300, 1);
        check("lit_drop_beat_maddr", maddr, 32'h18);
        cyc(0, 1, 32'h300, 1);
        check("lit_redir2_maddr", maddr, 32'h300);
        check("lit_redir2_wait", {31'b0, iready}, 32'd0);
        cyc(0, 1, 32'h300, 1);
        check("lit_redir2_idata", idata, 32'h1000_0300);

        // Fill with 0x304/0x308, then flush to 0x200
        for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 1);
        check("lit_refill_full", {31'b0, mvalid}, 32'd0);
        cyc(0, 1, 32'h200, 1);
        check("lit_flush_iready", {31'b0, iready}, 32'd0);
        cyc(0, 1, 32'h200, 1);
        check("lit_flush_maddr", maddr, 32'h200);
        cyc(0, 1, 32'h200, 1);
        check("lit_flush_idata", idata, 32'h1000_0200);
        cyc(0, 1, 32'h204, 1);
        check("lit_pushpop204", idata, 32'h1000_0204);
        cyc(0, 1, 32'h208, 1);
        check("lit_pushpop208", idata, 32'h1000_0208);

        // Address wrap at the top of the space
        cyc(0, 1, 32'hFFFF_FFF8, 1);
        cyc(0, 1, 32'hFFFF_FFF8, 1);
        check("lit_wrap_maddr0", maddr, 32'hFFFF_FFF8);
        cyc(0, 1, 32'hFFFF_FFF8, 1);
        check("lit_wrap_idata", idata, 32'h0FFF_FFF8);
        check("lit_wrap_maddr1", maddr, 32'hFFFF_FFFC);
        cyc(0, 1, 32'hFFFF_FFFC, 1);
        check("lit_wrap_maddr2", maddr, 32'h0000_0000);
        cyc(0, 1, 32'h0, 1);
        check("lit_wrap_head", idata, 32'h1000_0000);

        // Reset in the middle of a stalled transfer with a drop pending
        cyc(0, 1, 32'h100, 0);
        cyc(1, 0, 32'h0, 0);
        check("lit_midrst_mvalid", {31'b0, mvalid}, 32'd0);
        cyc(0, 0, 32'h0, 0);
        check("lit_postrst_maddr", maddr, 32'h0);
        cyc(0, 1, 32'h0, 1);
        cyc(0, 1, 32'h0, 1);
        check("lit_postrst_idata", idata, 32'h1000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
